// File: rtl/demux2_stream_if.sv
// Bundle of the demux2_stream signals: one interleaved input stream, two output
// channels (x = slot 0, y = slot 1) and the sync error pulse.
interface demux2_stream_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic             d_sync;
  logic             d_ready;
  logic [WIDTH-1:0] x;
  logic             x_valid;
  logic             x_ready;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic             y_ready;
  logic             sync_err;

  modport slave (
    input  d, d_valid, d_sync, x_ready, y_ready,
    output d_ready, x, x_valid, y, y_valid, sync_err
  );

  modport master (
    output d, d_valid, d_sync, x_ready, y_ready,
    input  d_ready, x, x_valid, y, y_valid, sync_err
  );
endinterface

// File: rtl/demux2_stream.sv
// Two-channel stream demultiplexer: alternate input beats are steered into two
// registered output channels, with a sync marker that forces a beat into slot 0.
module demux2_stream #(
  parameter int WIDTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  demux2_stream_if.slave  strm_io
);

  typedef enum logic {
    SLOT0 = 1'b0,
    SLOT1 = 1'b1
  } slot_e;

  slot_e      ptr_q, ptr_d;
  slot_e      tgt;
  logic       sync_err_q, sync_err_d;
  logic       accept;
  logic [1:0] ch_load;
  logic [1:0] ch_ready;
  logic [1:0] ch_valid;
  logic [1:0] ch_free;
  logic       d_ready_w;

  assign ch_ready = {strm_io.y_ready, strm_io.x_ready};
  // A channel can take a beat when empty or when its current beat drains this edge.
  assign ch_free  = ~ch_valid | ch_ready;

  always_comb begin
    tgt        = ptr_q;
    d_ready_w  = 1'b0;
    accept     = 1'b0;
    ch_load    = 2'b00;
    ptr_d      = ptr_q;
    sync_err_d = 1'b0;

    if (strm_io.d_valid && strm_io.d_sync) begin
      tgt = SLOT0;
    end
    d_ready_w = (tgt == SLOT0) ? ch_free[0] : ch_free[1];
    accept    = strm_io.d_valid && d_ready_w;

    if (accept) begin
      ch_load    = (tgt == SLOT0) ? 2'b01 : 2'b10;
      ptr_d      = (tgt == SLOT0) ? SLOT1 : SLOT0;
      sync_err_d = strm_io.d_sync && (ptr_q == SLOT1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= SLOT0;
      sync_err_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      sync_err_q <= sync_err_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : ch_g
      logic [WIDTH-1:0] data_q;
      logic             valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else if (ch_load[gi]) begin
          data_q  <= strm_io.d;
          valid_q <= 1'b1;
        end else if (valid_q && ch_ready[gi]) begin
          valid_q <= 1'b0;
        end
      end
    end
  endgenerate

  assign ch_valid = {ch_g[1].valid_q, ch_g[0].valid_q};

  assign strm_io.d_ready  = d_ready_w;
  assign strm_io.x        = ch_g[0].data_q;
  assign strm_io.x_valid  = ch_g[0].valid_q;
  assign strm_io.y        = ch_g[1].data_q;
  assign strm_io.y_valid  = ch_g[1].valid_q;
  assign strm_io.sync_err = sync_err_q;

endmodule
